// File: rtl/spi_adc_reader_if.sv
// Signal bundle between the SPI ADC reader and its environment (peripheral pins plus
// the downstream sample handshake).
interface spi_adc_reader_if;
  logic       start;
  logic       cont;
  logic       SCLK;
  logic       CS_n;
  logic       SDO;
  logic [7:0] data;
  logic       data_valid;
  logic       frame_err;
  logic       busy;

  // The reader drives the serial clock, chip select and the sample outputs.
  modport master (
    input  start, cont, SDO,
    output SCLK, CS_n, data, data_valid, frame_err, busy
  );

  modport slave (
    output start, cont, SDO,
    input  SCLK, CS_n, data, data_valid, frame_err, busy
  );
endinterface

// File: rtl/spi_adc_reader.sv
// SPI master that reads 16-bit frames (3 zeros, 8 data bits, 5 zeros) from an ADC and
// presents bits [12:5] with a one-cycle valid strobe and a framing-error flag.
module spi_adc_reader #(
  parameter int CLK_DIV     = 50,
  parameter int QUIET_SCLKS = 2
) (
  input logic              clk,
  input logic              rst_n,
  spi_adc_reader_if.master bus
);

  localparam int DIV_W = $clog2(CLK_DIV);
  localparam int QW    = (QUIET_SCLKS > 1) ? $clog2(QUIET_SCLKS) : 1;

  typedef enum logic [2:0] {
    IDLE,
    ARM,
    SHIFT,
    DONE,
    QUIET
  } state_t;

  state_t           state;
  logic [DIV_W-1:0] div_cnt;
  logic             sclk_q;
  logic             cs_n_q;
  logic [4:0]       bit_cnt;
  logic [15:0]      shift;
  logic [QW-1:0]    quiet_cnt;
  logic [7:0]       data_q;
  logic             data_valid_q;
  logic             frame_err_q;
  logic             busy_q;

  logic div_tc;
  logic rise_tick;

  assign div_tc    = (div_cnt == DIV_W'(CLK_DIV - 1));
  assign rise_tick = div_tc && !sclk_q;

  // SCLK runs continuously so the peripheral sees falling edges while deselected.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments only, so every register
    // samples the pre-edge values of its neighbours regardless of statement order.
    if (!rst_n) begin
      div_cnt <= '0;
      sclk_q  <= 1'b1;
    end else if (div_tc) begin
      div_cnt <= '0;
      sclk_q  <= ~sclk_q;
    end else begin
      div_cnt <= div_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= IDLE;
      cs_n_q       <= 1'b1;
      bit_cnt      <= '0;
      shift        <= '0;
      quiet_cnt    <= '0;
      data_q       <= '0;
      data_valid_q <= 1'b0;
      frame_err_q  <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      // NOTE: default-low here makes data_valid a single-cycle pulse; only DONE raises it.
      data_valid_q <= 1'b0;
      unique case (state)
        IDLE: begin
          if (bus.start || bus.cont) begin
            state  <= ARM;
            busy_q <= 1'b1;
          end
        end
        ARM: begin
          if (rise_tick) begin
            cs_n_q  <= 1'b0;
            bit_cnt <= 5'd16;
            state   <= SHIFT;
          end
        end
        SHIFT: begin
          // SDO changed CLK_DIV cycles ago on the falling edge, so it is stable here.
          if (rise_tick) begin
            shift   <= {shift[14:0], bus.SDO};
            bit_cnt <= bit_cnt - 5'd1;
            if (bit_cnt == 5'd1) begin
              cs_n_q <= 1'b1;
              state  <= DONE;
            end
          end
        end
        DONE: begin
          data_q       <= shift[12:5];
          frame_err_q  <= (|shift[15:13]) | (|shift[4:0]);
          data_valid_q <= 1'b1;
          quiet_cnt    <= '0;
          state        <= QUIET;
        end
        QUIET: begin
          if (rise_tick) begin
            if (quiet_cnt == QW'(QUIET_SCLKS - 1)) begin
              quiet_cnt <= '0;
              if (bus.cont) begin
                state <= ARM;
              end else begin
                state  <= IDLE;
                busy_q <= 1'b0;
              end
            end else begin
              quiet_cnt <= quiet_cnt + 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.SCLK       = sclk_q;
  assign bus.CS_n       = cs_n_q;
  assign bus.data       = data_q;
  assign bus.data_valid = data_valid_q;
  assign bus.frame_err  = frame_err_q;
  assign bus.busy       = busy_q;

endmodule

// File: tb/tb_spi_adc_reader.sv
// Self-checking bench for spi_adc_reader: behavioural ADC peripherals, a frame monitor
// with an expected-sample queue, table-driven single frames and multi-cycle corner cases.
module tb_spi_adc_reader;

  localparam int DIV    = 4;
  localparam int QUIET  = 2;
  localparam int BUDGET = 2000;

  typedef struct {
    logic [15:0] word;
    logic [7:0]  data;
    logic        err;
  } vec_t;

  typedef struct {
    logic [7:0] data;
    logic       err;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  int   cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  spi_adc_reader_if bus ();
  spi_adc_reader_if bus_s ();

  spi_adc_reader #(.CLK_DIV(DIV), .QUIET_SCLKS(QUIET)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus.master)
  );

  spi_adc_reader #(.CLK_DIV(2), .QUIET_SCLKS(1)) dut_s (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus_s.master)
  );

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ADC models: reload the word on SCLK falls while deselected, shift MSB first otherwise.
  logic [15:0] p_word, p_next, s_word, s_next;
  bit          p_random;
  int          p_idx, s_idx;

  always @(negedge bus.SCLK) begin
    if (bus.CS_n) begin
      p_word = p_random ? {3'b000, 8'($urandom), 5'b00000} : p_next;
      p_idx  = 15;
    end else if (p_idx >= 0) begin
      bus.SDO = p_word[p_idx[3:0]];
      p_idx--;
    end
  end

  always @(negedge bus_s.SCLK) begin
    if (bus_s.CS_n) begin
      s_word = s_next;
      s_idx  = 15;
    end else if (s_idx >= 0) begin
      bus_s.SDO = s_word[s_idx[3:0]];
      s_idx--;
    end
  end

  // Frame monitor for the main instance; outputs are sampled on the falling clk edge.
  exp_t sb[$];
  exp_t e;
  logic prev_cs, prev_sclk;
  bit   in_frame, have_rise;
  int   fall_cyc, rise_cyc, gap_falls;
  int   frames_started = 0;
  int   dv_count       = 0;

  always @(negedge clk) begin
    if (!rst_n) begin
      sb.delete();
      in_frame  = 1'b0;
      have_rise = 1'b0;
      prev_cs   = 1'b1;
      prev_sclk = 1'b1;
    end else begin
      if (prev_cs && !bus.CS_n) begin
        frames_started++;
        if (have_rise) begin
          check("cs_gap_ge_quiet", 32'((cyc - rise_cyc) >= QUIET * 2 * DIV), 1);
          check("cs_gap_has_sclk_fall", 32'(gap_falls > 0), 1);
        end
        fall_cyc = cyc;
        in_frame = 1'b1;
        sb.push_back('{p_word[12:5], (|p_word[15:13]) | (|p_word[4:0])});
      end
      if (!prev_cs && bus.CS_n && in_frame) begin
        check("frame_len", cyc - fall_cyc, 32 * DIV);
        rise_cyc  = cyc;
        have_rise = 1'b1;
        in_frame  = 1'b0;
        gap_falls = 0;
      end
      if (prev_sclk && !bus.SCLK && bus.CS_n) gap_falls++;
      if (bus.data_valid) begin
        dv_count++;
        check("dv_after_cs_rise", cyc - rise_cyc, 1);
        if (sb.size() == 0) begin
          check("dv_without_frame", 32'(bus.data_valid), 0);
        end else begin
          e = sb.pop_front();
          check("sb_data", 32'(bus.data), 32'(e.data));
          check("sb_frame_err", 32'(bus.frame_err), 32'(e.err));
        end
      end
      prev_cs   = bus.CS_n;
      prev_sclk = bus.SCLK;
    end
  end

  task automatic wait_cs(input logic lvl, input string name);
    int n = 0;
    while (bus.CS_n !== lvl && n < BUDGET) begin
      @(negedge clk);
      n++;
    end
    check(name, 32'(bus.CS_n), 32'(lvl));
  endtask

  task automatic wait_dv(input string name);
    int n = 0;
    while (bus.data_valid !== 1'b1 && n < BUDGET) begin
      @(negedge clk);
      n++;
    end
    check(name, 32'(bus.data_valid), 1);
  endtask

  task automatic wait_busy_low(input string name);
    int n = 0;
    while (bus.busy !== 1'b0 && n < 4 * BUDGET) begin
      @(negedge clk);
      n++;
    end
    check(name, 32'(bus.busy), 0);
  endtask

  task automatic pulse_start(output int start_cyc);
    @(posedge clk);
    #1 bus.start = 1'b1;
    start_cyc = cyc;
    @(posedge clk);
    #1 bus.start = 1'b0;
  endtask

  task automatic run_frame(input vec_t v, input string tag);
    int start_cyc;
    p_next = v.word;
    repeat (4 * DIV) @(posedge clk);
    pulse_start(start_cyc);
    wait_cs(1'b0, {tag, "_cs_low"});
    check({tag, "_start_latency"}, 32'((cyc - start_cyc - 1) <= 2 * DIV), 1);
    wait_dv({tag, "_dv_seen"});
    check({tag, "_data"}, 32'(bus.data), 32'(v.data));
    check({tag, "_frame_err"}, 32'(bus.frame_err), 32'(v.err));
    @(negedge clk);
    check({tag, "_dv_one_cycle"}, 32'(bus.data_valid), 0);
    wait_busy_low({tag, "_busy_low"});
    check({tag, "_busy_fall"}, cyc - rise_cyc, QUIET * 2 * DIV);
    check({tag, "_err_hold"}, 32'(bus.frame_err), 32'(v.err));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  vec_t vecs[5];
  int   d0, f0, n, sc, t_fall, t_rise, t1, t2;

  initial begin
    vecs[0] = '{16'h1FE0, 8'hFF, 1'b0};
    vecs[1] = '{16'h1FE4, 8'hFF, 1'b1};
    vecs[2] = '{16'h14A0, 8'hA5, 1'b0};
    vecs[3] = '{16'hE01F, 8'h00, 1'b1};
    vecs[4] = '{16'h0AA0, 8'h55, 1'b0};

    // NOTE: inputs change #1 after the rising edge and outputs are read on the falling
    // edge, so the bench never races the DUT's registers.
    rst_n       = 1'b0;
    bus.start   = 1'b0;
    bus.cont    = 1'b0;
    bus_s.start = 1'b0;
    bus_s.cont  = 1'b0;
    p_random    = 1'b0;
    p_next      = 16'h0000;
    s_next      = 16'h0000;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_sclk", 32'(bus.SCLK), 1);
    check("rst_cs_n", 32'(bus.CS_n), 1);
    check("rst_data", 32'(bus.data), 0);
    check("rst_data_valid", 32'(bus.data_valid), 0);
    check("rst_frame_err", 32'(bus.frame_err), 0);
    check("rst_busy", 32'(bus.busy), 0);
    @(posedge clk);
    #1 rst_n = 1'b1;

    for (int i = 0; i < 5; i++) run_frame(vecs[i], $sformatf("vec%0d", i));

    // Continuous mode with random samples, then stop cleanly.
    p_random = 1'b1;
    d0 = dv_count;
    @(posedge clk);
    #1 bus.cont = 1'b1;
    n = 0;
    while (dv_count < d0 + 20 && n < 5 * BUDGET) begin
      @(negedge clk);
      n++;
    end
    check("cont_20_frames", 32'((dv_count - d0) >= 20), 1);
    @(posedge clk);
    #1 bus.cont = 1'b0;
    wait_busy_low("cont_busy_low");
    f0 = frames_started;
    repeat (200) @(negedge clk);
    check("cont_stopped", frames_started - f0, 0);
    check("cont_sb_drained", sb.size(), 0);
    p_random = 1'b0;

    // start pulses every 10 cycles while busy must not queue a second frame.
    p_next = 16'h0AA0;
    repeat (4 * DIV) @(posedge clk);
    f0 = frames_started;
    d0 = dv_count;
    pulse_start(sc);
    n = 0;
    while (bus.busy && n < 100) begin
      repeat (10) @(posedge clk);
      #1;
      if (bus.busy) begin
        bus.start = 1'b1;
        @(posedge clk);
        #1 bus.start = 1'b0;
      end
      n++;
    end
    check("drop_busy_low", 32'(bus.busy), 0);
    repeat (100) @(negedge clk);
    check("drop_one_frame", frames_started - f0, 1);
    check("drop_one_dv", dv_count - d0, 1);
    check("drop_data", 32'(bus.data), 32'h55);

    // Reset during bit 8 aborts the frame with no valid strobe.
    p_next = 16'h1FE0;
    repeat (4 * DIV) @(posedge clk);
    pulse_start(sc);
    wait_cs(1'b0, "abort_cs_low");
    repeat (8 * 2 * DIV + DIV) @(posedge clk);
    #1 rst_n = 1'b0;
    d0 = dv_count;
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("abort_cs_n", 32'(bus.CS_n), 1);
    check("abort_sclk", 32'(bus.SCLK), 1);
    check("abort_data", 32'(bus.data), 0);
    check("abort_busy", 32'(bus.busy), 0);
    repeat (300) @(negedge clk);
    check("abort_no_dv", dv_count - d0, 0);
    run_frame(vecs[0], "after_abort");

    // Minimum divider instance: SCLK period 4, 64-cycle frame, quiet of one SCLK.
    s_next = 16'h0AA0;
    repeat (20) @(posedge clk);
    #1 bus_s.start = 1'b1;
    @(posedge clk);
    #1 bus_s.start = 1'b0;
    n = 0;
    while (bus_s.CS_n && n < BUDGET) begin @(negedge clk); n++; end
    check("s_cs_low", 32'(bus_s.CS_n), 0);
    t_fall = cyc;
    n = 0;
    while (bus_s.SCLK && n < 20) begin @(negedge clk); n++; end
    while (!bus_s.SCLK && n < 20) begin @(negedge clk); n++; end
    t1 = cyc;
    while (bus_s.SCLK && n < 20) begin @(negedge clk); n++; end
    while (!bus_s.SCLK && n < 20) begin @(negedge clk); n++; end
    t2 = cyc;
    check("s_sclk_period", t2 - t1, 4);
    n = 0;
    while (!bus_s.CS_n && n < BUDGET) begin @(negedge clk); n++; end
    check("s_frame_len", cyc - t_fall, 64);
    t_rise = cyc;
    @(negedge clk);
    check("s_dv_pulse", 32'(bus_s.data_valid), 1);
    check("s_dv_timing", cyc - t_rise, 1);
    check("s_data", 32'(bus_s.data), 32'h55);
    check("s_frame_err", 32'(bus_s.frame_err), 0);
    @(negedge clk);
    check("s_dv_one_cycle", 32'(bus_s.data_valid), 0);
    n = 0;
    while (bus_s.busy && n < BUDGET) begin @(negedge clk); n++; end
    check("s_busy_fall", cyc - t_rise, 4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/spi_adc_reader.md
Name: spi_adc_reader

Overview:
- SPI controller that reads 16-bit frames from the simulated SPI ADC peripheral (3 leading zeros, 8 data bits, 5 trailing zeros, MSB first, SDO updated on SCLK falling edge).
- Generates SCLK and CS_n, samples SDO, and hands the 8-bit sample (frame bits 12:5) to downstream logic with a one-cycle valid strobe.
- Sits between the system clock domain and the off-chip or simulated peripheral. It is the direct consumer of the peripheral's SDO stream.

Parameters:
- CLK_DIV, 50, clk cycles per SCLK half-period; SCLK period is 2*CLK_DIV; legal minimum is 2.
- QUIET_SCLKS, 2, full SCLK periods that CS_n is held high between frames; legal minimum is 1.

Ports:
- clk  input  1  system clock; all logic on its rising edge.
- rst_n  input  1  synchronous active-low reset.
- start  input  1  single-cycle request for one frame; ignored while busy=1.
- cont  input  1  when 1, a new frame starts automatically after each quiet period.
- SCLK  output  1  serial clock, registered.
- CS_n  output  1  active-low chip select, registered.
- SDO  input  1  serial data from the peripheral.
- data  output  8  last received sample, equal to frame bits [12:5].
- data_valid  output  1  one-cycle pulse when data updates.
- frame_err  output  1  set with data_valid if bits [15:13] or [4:0] of the frame are nonzero; holds until the next data_valid.
- busy  output  1  high from request acceptance until the quiet period ends.

Behaviour:
- Reset, sampled on the clk edge with rst_n=0:
  - SCLK=1, CS_n=1, data=0, data_valid=0, frame_err=0, busy=0.
  - Divider, bit counter and shift register are cleared; state is IDLE.
  - A reset mid-frame aborts the frame immediately and no data_valid is produced.
- SCLK generation:
  - SCLK is free-running whenever rst_n=1, including while CS_n is high. The peripheral reloads its word on falling edges seen with CS_n high.
  - The half-period counter counts 0..CLK_DIV-1. At terminal count SCLK toggles.
  - A "rise tick" is the edge where SCLK goes 0->1. A "fall tick" is the edge where SCLK goes 1->0.
- State machine:
  - IDLE: CS_n=1, busy=0. start=1 or cont=1 moves to ARM; busy goes to 1 on the next edge.
  - ARM: wait for a rise tick. On that tick CS_n goes 0, bit_cnt is set to 16, and the state moves to SHIFT.
  - SHIFT: on each rise tick, shift = {shift[14:0], SDO}, sampled at that same clk edge, and bit_cnt decrements.
    - Sampling happens CLK_DIV cycles after the peripheral's falling-edge update, so no synchronizer is required.
    - The first sample is taken one full SCLK period after CS_n falls.
  - SHIFT end: on the rise tick where bit_cnt reaches 0 (the 16th sample), CS_n goes 1 on that same edge and the state moves to DONE.
  - DONE: one clk cycle. data <= new_frame[12:5], frame_err <= |new_frame[15:13] | |new_frame[4:0], data_valid=1 for exactly this cycle. The state then moves to QUIET.
  - QUIET: count QUIET_SCLKS rise ticks with CS_n=1, then go to IDLE with busy=0. If cont=1 at that point, go to ARM without passing through IDLE.
- start asserted while busy=1 is dropped and not queued.
- start and cont asserted together are equivalent to cont alone.
- Deasserting cont mid-frame lets the current frame and its quiet period complete, then the block stops.
- Frame length from CS_n fall to CS_n rise is exactly 16*2*CLK_DIV clk cycles.
- Latency from an accepted start to CS_n low is at most 2*CLK_DIV cycles.
- data_valid asserts exactly 1 clk cycle after CS_n rises.

Test Plan:
- Reset, then one start with the peripheral's first word 0x1FE0 -> CS_n low for exactly 16 SCLK periods; data=0xFF, frame_err=0, data_valid high for one cycle, busy=0 after 2 quiet SCLKs.
- cont=1 with a random peripheral for 20 frames -> each data equals the peripheral's logged word bits [12:5]. CS_n-high gap per frame is ≥ QUIET_SCLKS periods and includes ≥1 SCLK falling edge. No frame_err.
- Force SDO=1 during bit 2 of a frame (word 0x1FE4) -> data=0xFF, frame_err=1. The next clean frame clears frame_err.
- start pulses every 10 cycles while busy -> exactly one frame per idle-to-idle window; no extra CS_n assertions.
- rst_n low for 1 cycle during bit 8 of SHIFT -> CS_n=1 and SCLK=1 on the next edge, no data_valid, data=0. The following start yields a correct frame.
- CLK_DIV=2, QUIET_SCLKS=1 -> SCLK period of 4 clk cycles, frame of 64 cycles with CS_n low; sample correct, data_valid timing as specified.
